// File: rtl/mdio_pkg.sv
// Shared constants, field boundaries and FSM encoding for the Clause 22 MDIO responder.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_BITS  = 2'b01;

  localparam int REG_AW = 5;
  localparam int REG_DW = 16;
  localparam int NUM_REGS = 32;

  // Bit numbers (counted from 1 at the first ST bit) that close each field.
  localparam logic [5:0] BIT_ST_END  = 6'd2;
  localparam logic [5:0] BIT_OP_END  = 6'd4;
  localparam logic [5:0] BIT_PHY_END = 6'd9;
  localparam logic [5:0] BIT_REG_END = 6'd14;
  localparam logic [5:0] BIT_TA1     = 6'd15;
  localparam logic [5:0] BIT_TA_END  = 6'd16;
  localparam logic [5:0] BIT_LAST    = 6'd32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_SKIP
  } mdio_state_e;

  // PHY identifier registers ignore MDIO writes.
  function automatic logic is_read_only(input logic [REG_AW-1:0] addr);
    return (addr == 5'd2) || (addr == 5'd3);
  endfunction

endpackage

// File: rtl/mdc_edge_sync.sv
// Brings the asynchronous MDC/MDIO pins into clk and flags each MDC rising edge
// together with the MDIO value sampled on it.
module mdc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_d;

  // mdc_rise and mdio_s are registered together so the bit always lines up with its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_d     <= 1'b0;
      mdc_rise  <= 1'b0;
      mdio_s    <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
      mdc_d     <= mdc_sync[SYNC_STAGES-1];
      mdc_rise  <= mdc_sync[SYNC_STAGES-1] & ~mdc_d;
      mdio_s    <= mdio_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause 22 MDIO responder: decodes oversampled frames, answers reads on
// MDIO and owns the 32x16 management register file.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h001C,
  parameter logic [15:0] PHY_ID2      = 16'hC915,
  parameter int          MIN_PREAMBLE = 32,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        host_wr_en,
  input  logic [4:0]  host_wr_addr,
  input  logic [15:0] host_wr_data
);

  localparam int PRE_W = (MIN_PREAMBLE < 1) ? 1 : $clog2(MIN_PREAMBLE + 1);
  localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PREAMBLE);

  logic              mdc_rise;
  logic              mdio_s;
  mdio_state_e       state;
  logic [5:0]        bit_cnt;
  logic [5:0]        bit_num;
  logic [PRE_W-1:0]  pre_cnt;
  logic [14:0]       shift_in;
  logic [REG_AW-1:0] field5;
  logic              is_read;
  logic [REG_AW-1:0] reg_addr;
  logic [REG_DW-1:0] rd_shift;
  logic [REG_DW-1:0] regs [NUM_REGS];
  logic              commit;
  logic [REG_DW-1:0] commit_data;

  mdc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .mdc_i    (mdc_i),
    .mdio_i   (mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  // bit_cnt holds the number of the last frame bit taken; bit_num is the one arriving now.
  assign bit_num     = bit_cnt + 6'd1;
  assign field5      = {shift_in[3:0], mdio_s};
  assign commit      = mdc_rise && (state == S_WDATA) && (bit_num == BIT_LAST);
  assign commit_data = {shift_in, mdio_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      pre_cnt  <= '0;
      shift_in <= '0;
      is_read  <= 1'b0;
      reg_addr <= '0;
      rd_shift <= '0;
      mdio_o   <= 1'b0;
      mdio_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= commit;
      if (commit) begin
        wr_addr <= reg_addr;
        wr_data <= commit_data;
      end
      if (mdc_rise) begin
        bit_cnt  <= bit_num;
        shift_in <= {shift_in[13:0], mdio_s};
        unique case (state)
          S_IDLE: begin
            bit_cnt <= '0;
            if (mdio_s) begin
              if (pre_cnt < PRE_MIN) pre_cnt <= pre_cnt + PRE_W'(1);
            end else if (pre_cnt >= PRE_MIN) begin
              // First ST bit: the count is spent, the next frame needs a fresh preamble.
              state   <= S_ST;
              bit_cnt <= 6'd1;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            state <= (mdio_s == ST_BITS[0]) ? S_OP : S_IDLE;
          end
          S_OP: begin
            if (bit_num == BIT_OP_END) begin
              unique case ({shift_in[0], mdio_s})
                OP_READ: begin
                  is_read <= 1'b1;
                  state   <= S_PHYAD;
                end
                OP_WRITE: begin
                  is_read <= 1'b0;
                  state   <= S_PHYAD;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
          S_PHYAD: begin
            if (bit_num == BIT_PHY_END) state <= (field5 == PHY_ADDR) ? S_REGAD : S_SKIP;
          end
          S_REGAD: begin
            if (bit_num == BIT_REG_END) begin
              reg_addr <= field5;
              rd_shift <= regs[field5];
              state    <= S_TA;
            end
          end
          S_TA: begin
            if (bit_num == BIT_TA1) begin
              if (is_read) begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b0;
              end
            end else if (bit_num == BIT_TA_END) begin
              if (is_read) begin
                mdio_o   <= rd_shift[15];
                rd_shift <= {rd_shift[14:0], 1'b0};
                state    <= S_RDATA;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (bit_num == BIT_LAST) begin
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              mdio_o   <= rd_shift[15];
              rd_shift <= {rd_shift[14:0], 1'b0};
            end
          end
          S_WDATA: begin
            if (bit_num == BIT_LAST) state <= S_IDLE;
          end
          S_SKIP: begin
            // Foreign PHY address: sit out the rest of the frame through bit 32.
            if (bit_num == BIT_LAST) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Host writes land first so a same-cycle MDIO commit to the same address overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 2) ? PHY_ID1 : (i == 3) ? PHY_ID2 : '0;
      end
    end else begin
      if (host_wr_en) regs[host_wr_addr] <= host_wr_data;
      if (commit && !is_read_only(reg_addr)) regs[reg_addr] <= commit_data;
    end
  end

endmodule
